// File: rtl/sr_drive_if.sv
`default_nettype none
// ============================================================================
//  Module   : sr_drive_if
//  Brief    : Target handshake, SR excitation and bank feedback bundle
//  Revision : 1.0
// ============================================================================
interface sr_drive_if #(
    parameter int W         = 4,
    parameter int MAX_RETRY = 2
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

    logic           tgt_valid;
    logic           tgt_ready;
    logic [W-1:0]   tgt_data;
    logic [W-1:0]   q_fb;
    logic [2*W-1:0] sr_out;
    logic           busy;
    logic           done;
    logic           err;
    logic [RW-1:0]  retry_cnt;

    modport master (
        output tgt_valid, tgt_data, q_fb,
        input  tgt_ready, sr_out, busy, done, err, retry_cnt
    );

    modport slave (
        input  tgt_valid, tgt_data, q_fb,
        output tgt_ready, sr_out, busy, done, err, retry_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sr_drive_ctrl
//  Brief    : Drives a bank of SR flip-flops to a target word, verifies, retries
//  Revision : 1.0
// ============================================================================
module sr_drive_ctrl #(
    parameter int W          = 4,
    parameter int SETTLE_CYC = 1,
    parameter int MAX_RETRY  = 2
) (
    input  wire logic   clk,
    input  wire logic   rst,
    sr_drive_if.slave   bus
);
    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    localparam logic [1:0]    c_idle        = 2'd0;
    localparam logic [1:0]    c_issue       = 2'd1;
    localparam logic [1:0]    c_settle      = 2'd2;
    localparam logic [1:0]    c_check       = 2'd3;
    localparam logic [RW-1:0] c_max_retry   = RW'(MAX_RETRY);
    localparam logic [CW-1:0] c_settle_last = CW'(SETTLE_CYC - 1);

    logic [1:0]     r_state;
    logic [2*W-1:0] r_sr;
    logic           r_ready;
    logic           r_busy;
    logic           r_done;
    logic           r_err;
    logic [RW-1:0]  r_retry;
    logic [CW-1:0]  r_cnt;
    logic [W-1:0]   r_tgt;
    logic           r_nochg;

    logic [1:0]     w_state_nx;
    logic [2*W-1:0] w_sr_nx;
    logic           w_done_nx;
    logic           w_err_nx;
    logic [RW-1:0]  w_retry_nx;
    logic [CW-1:0]  w_cnt_nx;
    logic           w_nochg_nx;
    logic           w_load;

    // An unknown feedback bit fails the equality test and is steered toward t.
    function automatic logic [2*W-1:0] f_excite(input logic [W-1:0] t,
                                                input logic [W-1:0] q);
        logic [2*W-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            if (q[i] == t[i])
                c[2*i +: 2] = 2'b00;
            else
                c[2*i +: 2] = t[i] ? 2'b10 : 2'b01;
        end
        return c;
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_sr_nx    = '0;
        w_done_nx  = 1'b0;
        w_err_nx   = 1'b0;
        w_retry_nx = r_retry;
        w_cnt_nx   = r_cnt;
        w_nochg_nx = r_nochg;
        w_load     = 1'b0;
        case (r_state)
            c_idle: begin
                if (bus.tgt_valid) begin
                    w_load     = 1'b1;
                    w_retry_nx = '0;
                    // Already-matching target skips excitation but still spends one busy cycle.
                    if (bus.tgt_data == bus.q_fb) begin
                        w_state_nx = c_check;
                        w_nochg_nx = 1'b1;
                    end else begin
                        w_state_nx = c_issue;
                        w_nochg_nx = 1'b0;
                        w_sr_nx    = f_excite(bus.tgt_data, bus.q_fb);
                    end
                end
            end
            c_issue: begin
                w_state_nx = c_settle;
                w_cnt_nx   = c_settle_last;
            end
            c_settle: begin
                if (r_cnt == '0)
                    w_state_nx = c_check;
                else
                    w_cnt_nx = r_cnt - CW'(1);
            end
            default: begin
                if (r_nochg || (bus.q_fb == r_tgt)) begin
                    w_state_nx = c_idle;
                    w_done_nx  = 1'b1;
                end else if (r_retry < c_max_retry) begin
                    w_state_nx = c_issue;
                    w_retry_nx = r_retry + RW'(1);
                    w_sr_nx    = f_excite(r_tgt, bus.q_fb);
                end else begin
                    w_state_nx = c_idle;
                    w_err_nx   = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
            r_sr    <= '0;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_retry <= '0;
            r_cnt   <= '0;
            r_tgt   <= '0;
            r_nochg <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_sr    <= w_sr_nx;
            r_ready <= (w_state_nx == c_idle);
            r_busy  <= (w_state_nx != c_idle);
            r_done  <= w_done_nx;
            r_err   <= w_err_nx;
            r_retry <= w_retry_nx;
            r_cnt   <= w_cnt_nx;
            r_nochg <= w_nochg_nx;
            if (w_load)
                r_tgt <= bus.tgt_data;
        end
    end

    assign bus.sr_out    = r_sr;
    assign bus.tgt_ready = r_ready;
    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
    assign bus.retry_cnt = r_retry;
endmodule
`default_nettype wire

// File: tb/tb_sr_drive_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sr_drive_ctrl
//  Brief    : Self-checking bench for sr_drive_ctrl with an SR bank model
//  Revision : 1.0
// ============================================================================
module tb_sr_drive_ctrl;
    localparam int W          = 2;
    localparam int SETTLE_CYC = 1;
    localparam int MAX_RETRY  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sr_drive_if #(.W(W), .MAX_RETRY(MAX_RETRY)) bus ();

    sr_drive_ctrl #(.W(W), .SETTLE_CYC(SETTLE_CYC), .MAX_RETRY(MAX_RETRY)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // SR storage cells driven by the controller; stuck forces the feedback to 0.
    logic [W-1:0] bank_q = '0;
    logic         stuck  = 1'b0;
    assign bus.q_fb = stuck ? '0 : bank_q;

    always @(posedge clk) begin
        for (int i = 0; i < W; i++) begin
            if (bus.sr_out[2*i+1])
                bank_q[i] <= 1'b1;
            else if (bus.sr_out[2*i])
                bank_q[i] <= 1'b0;
        end
    end

    typedef struct packed {
        logic [2*W-1:0] sr;
        logic           busy;
        logic           done;
        logic           err;
        logic [1:0]     retry;
        logic [W-1:0]   tgt;
    } exp_t;

    exp_t       exp_q[$];
    logic       m_ready = 1'b1;
    logic [1:0] m_retry = 2'd0;
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [2*W-1:0] sr, input logic busy, input logic done,
                                input logic err, input int retry, input logic [W-1:0] tgt);
        exp_t e;
        e.sr    = sr;
        e.busy  = busy;
        e.done  = done;
        e.err   = err;
        e.retry = 2'(retry);
        e.tgt   = tgt;
        return e;
    endfunction

    function automatic logic [2*W-1:0] excite(input logic [W-1:0] t, input logic [W-1:0] fb);
        logic [W-1:0]   s;
        logic [W-1:0]   r;
        logic [2*W-1:0] c;
        s = t & ~fb;
        r = ~t & fb;
        for (int i = 0; i < W; i++) begin
            c[2*i+1] = s[i];
            c[2*i]   = r[i];
        end
        return c;
    endfunction

    // Expected per-cycle outputs for one transaction, starting the cycle after accept.
    task automatic plan(input logic [W-1:0] t, input logic [W-1:0] q0);
        logic [W-1:0]   q;
        logic [W-1:0]   fb;
        logic [2*W-1:0] code;
        q  = q0;
        fb = stuck ? '0 : q;
        if (fb == t) begin
            exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b0, 0, t));
            exp_q.push_back(mk('0, 1'b0, 1'b1, 1'b0, 0, t));
        end else begin
            for (int rr = 0; rr <= MAX_RETRY; rr++) begin
                code = excite(t, fb);
                exp_q.push_back(mk(code, 1'b1, 1'b0, 1'b0, rr, t));
                q = (q | (t & ~fb)) & ~(~t & fb);
                for (int k = 0; k < SETTLE_CYC; k++)
                    exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b0, rr, t));
                exp_q.push_back(mk('0, 1'b1, 1'b0, 1'b0, rr, t));
                fb = stuck ? '0 : q;
                if (fb == t) begin
                    exp_q.push_back(mk('0, 1'b0, 1'b1, 1'b0, rr, t));
                    break;
                end else if (rr == MAX_RETRY) begin
                    exp_q.push_back(mk('0, 1'b0, 1'b0, 1'b1, rr, t));
                end
            end
        end
    endtask

    task automatic step(input logic v, input logic [W-1:0] d, input logic r);
        exp_t e;
        logic pair11;
        rst           = r;
        bus.tgt_valid = v;
        bus.tgt_data  = d;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            m_retry = 2'd0;
        end else if (v && m_ready) begin
            plan(d, bank_q);
        end
        @(negedge clk);
        if (exp_q.size() > 0)
            e = exp_q.pop_front();
        else
            e = mk('0, 1'b0, 1'b0, 1'b0, int'(m_retry), '0);
        m_retry = e.retry;
        m_ready = !e.busy;
        pair11 = 1'b0;
        for (int i = 0; i < W; i++)
            if (bus.sr_out[2*i +: 2] == 2'b11) pair11 = 1'b1;
        check("sr_out",    32'(bus.sr_out),    32'(e.sr));
        check("busy",      32'(bus.busy),      32'(e.busy));
        check("tgt_ready", 32'(bus.tgt_ready), 32'(!e.busy));
        check("done",      32'(bus.done),      32'(e.done));
        check("err",       32'(bus.err),       32'(e.err));
        check("retry_cnt", 32'(bus.retry_cnt), 32'(e.retry));
        check("no_sr_11",  32'(pair11),        32'd0);
        if (e.done)
            check("q_fb_at_done", 32'(bus.q_fb), 32'(e.tgt));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0);
    endtask

    initial begin
        logic [W-1:0] d;
        logic         v;
        logic         r;
        bus.tgt_valid = 1'b0;
        bus.tgt_data  = '0;

        // Reset and first set operation from q=00.
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        idle(2);
        step(1'b1, 2'b10, 1'b0);
        idle(6);

        // Set one bit while resetting the other.
        step(1'b1, 2'b01, 1'b0);
        idle(6);

        // Target equal to current state.
        step(1'b1, bank_q, 1'b0);
        idle(4);

        // Feedback stuck at zero exhausts the retries.
        stuck = 1'b1;
        idle(1);
        step(1'b1, 2'b11, 1'b0);
        idle(14);
        stuck = 1'b0;
        idle(1);

        // Changing data held valid while busy.
        for (int i = 0; i < 14; i++)
            step(1'b1, W'($urandom), 1'b0);
        idle(6);

        // Reset lands during SETTLE.
        d = ~bank_q;
        step(1'b1, d, 1'b0);
        step(1'b0, '0, 1'b0);
        step(1'b0, '0, 1'b1);
        idle(6);

        // Random traffic with occasional stuck feedback and resets.
        for (int n = 0; n < 500; n++) begin
            r = ($urandom % 60) == 0;
            if (exp_q.size() == 0 && ($urandom % 6) == 0) begin
                stuck = 1'($urandom % 4 == 0);
                step(1'b0, '0, r);
            end else begin
                v = 1'(($urandom % 3) != 0);
                step(v, W'($urandom), r);
            end
        end
        stuck = 1'b0;
        idle(12);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
